// File: rtl/riscv_defines.sv
// riscv_defines: shared RV M-extension operation and muldiv FSM state types.
package riscv_defines;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step on magnitudes.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_n,
    output logic [XLEN-1:0] quo_n
);
    logic [XLEN:0] sh;
    logic [XLEN:0] df;

    // quo shifts the dividend out at the top while quotient bits enter at the bottom
    assign sh    = {rem, quo[XLEN-1]};
    assign df    = sh - {1'b0, dvs};
    assign rem_n = df[XLEN] ? sh[XLEN-1:0] : df[XLEN-1:0];
    assign quo_n = {quo[XLEN-2:0], ~df[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshakes.
module muldiv_unit
    import riscv_defines::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int CW0 = $clog2(XLEN + 1) > 6 ? $clog2(XLEN + 1) : 6;
    localparam int CW  = $clog2(MUL_LATENCY + 1) > CW0 ? $clog2(MUL_LATENCY + 1) : CW0;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state;
    muldiv_op_t        op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    logic [2*XLEN-1:0] mp;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   quo_n;
    logic [XLEN-1:0]   special;
    logic              neg_q;
    logic              neg_r;
    logic              dsg;
    logic              na;
    logic              nb;
    logic              dz;
    logic              ovf;

    function automatic logic [XLEN-1:0] pick(input logic lo, input logic [2*XLEN-1:0] p);
        return lo ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign ready_o = state == IDLE;
    // MULHU is the only op with unsigned rs1; only MUL/MULH treat rs2 as signed
    assign ea      = {{XLEN{(op_i[1:0] != 2'b11) & a_i[XLEN-1]}}, a_i};
    assign eb      = {{XLEN{~op_i[1] & b_i[XLEN-1]}}, b_i};
    assign mp      = ea * eb;
    assign dsg     = ~op_i[0];
    assign na      = dsg & a_i[XLEN-1];
    assign nb      = dsg & b_i[XLEN-1];
    assign dz      = b_i == '0;
    assign ovf     = dsg && a_i == MIN && b_i == '1;
    assign special = dz ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN);

    muldiv_div_step #(.XLEN(XLEN)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dvs   (dvs),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= MD_MUL;
            cnt      <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (flush_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    op    <= muldiv_op_t'(op_i);
                    tag_o <= tag_i;
                    cnt   <= '0;
                    if (!op_i[2]) begin
                        prod <= mp;
                        if (MUL_LATENCY == 1) begin
                            result_o <= pick(op_i == MD_MUL, mp);
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end else if (dz || ovf) begin
                        result_o <= special;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        rem   <= '0;
                        quo   <= na ? -a_i : a_i;
                        dvs   <= nb ? -b_i : b_i;
                        neg_q <= na ^ nb;
                        neg_r <= na;
                        state <= DIV;
                    end
                end
                MUL: if (cnt == CW'(MUL_LATENCY - 2)) begin
                    result_o <= pick(op == MD_MUL, prod);
                    valid_o  <= 1'b1;
                    state    <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    rem   <= rem_n;
                    quo   <= quo_n;
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CW'(XLEN - 1) ? FIX : DIV;
                end
                FIX: begin
                    result_o <= op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
                    valid_o  <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (ready_i) begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [4:0]  tag_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  tag_o;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o)
    );

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] up;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        up = {32'b0, a} * {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: return 32'(sa * sb);
            3'd1: return 32'((sa * sb) >>> 32);
            3'd2: return 32'((sa * ub) >>> 32);
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 2;
        if (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
        return 34;
    endfunction

    // drive one request, wait (bounded) for the result, then consume it
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                         output logic [31:0] res, output logic [4:0] otag, output int lat, output logic rdy_after);
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; tag_i = tag; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_o) lat = 999;
        res = result_o;
        otag = tag_o;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        rdy_after = ready_o;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0 || tag_o !== 5'd0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b result=%h tag=%h want 1 0 0 0", ready_o, valid_o, result_o, tag_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] want [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                   32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int          wlat [12] = '{2, 2, 2, 2, 34, 34, 34, 34, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 3), res, otag, lat, rdy);
            checks++;
            if (res !== want[i] || otag !== 5'(i + 3) || lat != wlat[i] || rdy !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d]: result=%h tag=%0d lat=%0d ready=%b want %h %0d %0d 1",
                         i, res, otag, lat, rdy, want[i], i + 3, wlat[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  tag, otag;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(op, a, b, tag, res, otag, lat, rdy);
            checks++;
            if (res !== ref_res(op, a, b) || otag !== tag || lat != ref_lat(op, a, b)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h tag=%0d lat=%0d want %h %0d %0d",
                         i, op, a, b, res, otag, lat, ref_res(op, a, b), tag, ref_lat(op, a, b));
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic seen;
        @(negedge clk);
        op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; tag_i = 5'd9; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid_o) begin
            errors++;
            $display("FAIL backpressure_valid: valid_o never rose within 100 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            op_i = 3'd0; a_i = 32'd3; b_i = 32'd3; tag_i = 5'd1; valid_i = i[0];
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1 || result_o !== 32'd14 || tag_o !== 5'd9 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b result=%h tag=%0d ready=%b want 1 0000000e 9 0",
                         i, valid_o, result_o, tag_o, ready_o);
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b valid=%b want 1 0", ready_o, valid_o);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= valid_o;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_ignored: valid_o rose from a request made while busy");
        end
    endtask

    task automatic test_flush;
        logic seen;
        @(negedge clk);
        op_i = 3'd4; a_i = 32'hFFFFFFF9; b_i = 32'd2; tag_i = 5'd4; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_div: ready=%b valid=%b want 1 0", ready_o, valid_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= valid_o;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_quiet: valid_o rose after flush");
        end
        op_i = 3'd0; a_i = 32'd2; b_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        seen = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: ready=%b want 1", ready_o);
        end
        repeat (5) begin
            @(negedge clk);
            seen |= valid_o;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_quiet: valid_o rose for a flushed request");
        end
        op_i = 3'd5; a_i = 32'd5; b_i = 32'd0; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: ready=%b valid=%b want 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        logic        rdy;
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd6; b_i = 32'd7; tag_i = 5'd17; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0 || tag_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h tag=%h want 1 0 0 0", ready_o, valid_o, result_o, tag_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd0, 32'd6, 32'd7, 5'd2, res, otag, lat, rdy);
        checks++;
        if (res !== 32'd42 || otag !== 5'd2 || lat != 2) begin
            errors++;
            $display("FAIL reset_recover: result=%h tag=%0d lat=%0d want 0000002a 2 2", res, otag, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M/RV64M execute unit. It performs MUL/MULH/MULHSU/MULHU through a configurable-latency multiplier and DIV/DIVU/REM/REMU through a radix-2 iterative divider. It sits beside the single-cycle ALU in the execute stage and takes over whenever the ALU decoder selects the M-extension operation group. It handshakes with the pipeline through valid/ready on both sides and carries a destination tag for writeback.

## Interface

**Parameters**

- XLEN, 32: operand/result width; even, ≥ 8.
- MUL_LATENCY, 2: cycles from accept to valid_o for multiplies; ≥ 1.
- TAG_W, 5: width of the passthrough destination tag.

**Ports**

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; equals (state == IDLE).
- op_i  in  3  muldiv_op_t, encoded as funct3.
- a_i, b_i  in  XLEN  rs1 and rs2 operands.
- tag_i  in  TAG_W  destination tag.
- flush_i  in  1  synchronous kill of any in-flight operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.
- tag_o  out  TAG_W  tag of the result.

## Operation

- **Accept.** A request is accepted on a rising edge where valid_i && ready_o && !flush_i. At that edge op, operands and tag are captured.
- **States:** IDLE, MUL, DIV, FIX, DONE.
- **IDLE → DONE directly**, one cycle, in these cases:
  - MUL_LATENCY = 1.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a_i.
  - Signed overflow: DIV gives 0x80..0 (a_i); REM gives 0.
- **MUL.**
  - Form the (2·XLEN)-bit product of sign/zero-extended operands. Extension: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Hold for MUL_LATENCY−1 cycles, then go to DONE.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
- **DIV.**
  - Operate on magnitudes (signed ops take two's-complement absolute values at accept).
  - Run XLEN restoring iterations, one quotient bit per cycle, on a 6-bit-or-wider iteration counter, then go to FIX.
- **FIX.**
  - Negate the quotient if the operand signs differ (DIV only).
  - Negate the remainder if the dividend was negative (REM only).
  - Go to DONE.
- **DONE.**
  - valid_o = 1. result_o and tag_o are held stable.
  - valid_o && ready_i returns the unit to IDLE.
- **Flush.**
  - Any state goes to IDLE at the next edge and drops valid_o.
  - Flush beats an accept in the same cycle; that request is dropped.
  - A flush in DONE discards the pending result even if ready_i is high.
- **Reset mid-operation.** Immediate return to IDLE, with all outputs at their reset values.
- **Requests outside IDLE.** Not accepted. valid_i is ignored while ready_o = 0.
- **Throughput.** No back-to-back: at least one IDLE cycle between results.

## Timing

- **Reset values:** state IDLE, ready_o = 1, valid_o = 0, result_o = 0, tag_o = 0.
- **Latency** counts cycles from the accept edge to the first cycle valid_o is high:
  - Multiply: MUL_LATENCY.
  - Divide/remainder: XLEN + 2 (34 at XLEN = 32).
  - Divide-by-zero and overflow: 1.
- **Outputs.**
  - valid_o, result_o and tag_o are registered.
  - ready_o is a decode of the state register.
- **Backpressure.** With ready_i = 0 in DONE, valid_o, result_o and tag_o must not change, for any number of cycles.

## Structure

- **Shared package riscv_defines** gains:
  - typedef enum logic [2:0] muldiv_op_t: MD_MUL = 0, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU (matching funct3).
  - typedef enum muldiv_state_t: IDLE, MUL, DIV, FIX, DONE.
- **Sub-module muldiv_div_step.** Combinational single restoring step over XLEN-bit remainder/quotient.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and next quotient.
- **Top.** FSM, operand capture, multiplier staging and sign fix-up stay in muldiv_unit.

## Test plan

All scenarios run at XLEN = 32 and MUL_LATENCY = 2.

1. **Low product.** MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB; valid_o 2 cycles after accept; tag echoed.
2. **High products.**
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
3. **Signed divide.**
   - DIV −7 / 2 → 0xFFFFFFFD after 34 cycles.
   - REM −7 / 2 → 0xFFFFFFFF.
   - DIVU 100 / 7 → 14.
   - REMU 100 / 7 → 2.
4. **Corner cases**, each valid 1 cycle after accept:
   - DIVU 5 / 0 → 0xFFFFFFFF.
   - REM 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0.
5. **Backpressure.**
   - Hold ready_i = 0 for 5 cycles in DONE: result and tag stay stable and ready_o stays 0.
   - valid_i pulses during this window are ignored.
   - Raising ready_i gives IDLE the next cycle.
6. **Flush and reset.**
   - flush_i on cycle 10 of a DIV: valid_o never rises and ready_o = 1 the next cycle.
   - flush_i with valid_i in IDLE: no accept.
   - rst_n low mid-MUL: outputs at reset values immediately.
